pwm_gen: RTL and testbench

Speed PWM generator for the smart-car motor drivers. It consumes the 13-bit speed code produced by the key-to-speed mapping stage and produces one motor PWM waveform. The period is fixed. Duty changes take effect only at period boundaries, with a bounded per-period ramp for soft start and slew. It sits between the speed-selection logic and the H-bridge enable pins.

---
 rtl/pwm_gen_if.sv | 25 ++
 rtl/pwm_gen.sv | 89 ++++++++
 tb/tb_pwm_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_gen_if.sv
// pwm_gen control/status bundle.
// Speed request in, motor PWM and status out.
interface pwm_gen_if;
    logic [12:0] duty_in;
    logic        enable;
    logic        pwm_out;
    logic [12:0] duty_act;
    logic        period_tick;

    modport master (
        output duty_in,
        output enable,
        input  pwm_out,
        input  duty_act,
        input  period_tick
    );

    modport slave (
        input  duty_in,
        input  enable,
        output pwm_out,
        output duty_act,
        output period_tick
    );
endinterface

// File: rtl/pwm_gen.sv
// Fixed-period motor PWM with per-period duty ramp.
// Duty only moves at wrap edges, by at most RAMP_STEP.
module pwm_gen #(
    parameter int unsigned PERIOD    = 5000,
    parameter int unsigned RAMP_STEP = 500
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    pwm_gen_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [13:0] PER14  = 14'(PERIOD);
    localparam logic [13:0] STEP14 = 14'(RAMP_STEP);
    localparam logic [12:0] LAST   = 13'(PERIOD - 1);

    state_t      state_q;
    logic [12:0] cnt_q;
    logic [12:0] duty_q;
    logic        pwm_q;
    logic        tick_q;

    logic [13:0] tgt;
    logic [13:0] act;
    logic [13:0] up_diff;
    logic [13:0] dn_diff;
    logic [13:0] ramp;
    logic        wrap;
    logic [12:0] cnt_d;
    logic [12:0] duty_d;

    // Next counter/duty: clamp target, step duty toward it at the wrap.
    always_comb begin
        tgt     = ({1'b0, bus.duty_in} > PER14) ? PER14 : {1'b0, bus.duty_in};
        act     = {1'b0, duty_q};
        up_diff = tgt - act;
        dn_diff = act - tgt;
        ramp    = act;
        if (STEP14 == 14'd0) begin
            ramp = tgt;
        end else if (act < tgt) begin
            ramp = act + ((up_diff > STEP14) ? STEP14 : up_diff);
        end else if (act > tgt) begin
            ramp = act - ((dn_diff > STEP14) ? STEP14 : dn_diff);
        end
        wrap   = (cnt_q == LAST);
        cnt_d  = wrap ? 13'd0 : cnt_q + 13'd1;
        duty_d = wrap ? ramp[12:0] : duty_q;
    end

    // IDLE/RUN state machine; outputs registered for the upcoming cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    duty_q <= '0;
                    pwm_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (bus.enable) state_q <= RUN;
                end
                RUN: begin
                    if (!bus.enable) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        duty_q  <= '0;
                        pwm_q   <= 1'b0;
                        tick_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_d;
                        duty_q <= duty_d;
                        pwm_q  <= (cnt_d < duty_d);
                        tick_q <= (cnt_d == LAST);
                    end
                end
            endcase
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.duty_act    = duty_q;
    assign bus.period_tick = tick_q;
endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: period-level scoreboard of duty/high count.
// DUT A ramps (step 5), DUT B applies targets at once (step 0).
module tb_pwm_gen;
    localparam int PER = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_gen_if ifa();
    pwm_gen_if ifb();

    pwm_gen #(.PERIOD(PER), .RAMP_STEP(5)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .bus(ifa)
    );
    pwm_gen #(.PERIOD(PER), .RAMP_STEP(0)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .bus(ifb)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int q[$];
    int sel    = 0;
    int step   = 5;
    int m_act  = 0;
    int acc    = 0;
    int late   = 0;
    int pcyc   = 0;
    bit fell   = 0;

    logic        pwm_s;
    logic [12:0] duty_s;
    logic        tick_s;
    assign pwm_s  = sel != 0 ? ifb.pwm_out     : ifa.pwm_out;
    assign duty_s = sel != 0 ? ifb.duty_act    : ifa.duty_act;
    assign tick_s = sel != 0 ? ifb.period_tick : ifa.period_tick;

    task automatic chk(input string tag, input int obs, input int want);
        n_chk++;
        if (obs != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int nxt(input int d, input int t, input int s);
        int tc;
        tc = (t > PER) ? PER : t;
        if (s == 0) return tc;
        if (d < tc) return (tc - d > s) ? d + s : tc;
        if (d > tc) return (d - tc > s) ? d - s : tc;
        return d;
    endfunction

    // Per-period monitor: high count, shape, length, duty at the tick.
    always @(negedge clk) begin
        if (!rst) begin
            if (pwm_s) begin
                if (fell) late++;
                acc++;
            end else begin
                fell = 1;
            end
            pcyc++;
            if (tick_s) begin
                if (q.size() == 0) begin
                    chk("tick_unexp", 1, 0);
                end else begin
                    int e;
                    e = q.pop_front();
                    chk("duty_act", int'(duty_s), e);
                    chk("high_cnt", acc, e);
                    chk("shape", late, 0);
                    chk("period_len", pcyc, PER);
                end
                acc = 0; late = 0; fell = 0; pcyc = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        acc = 0; late = 0; fell = 0; pcyc = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            cyc();
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic set_duty(input int d);
        if (sel != 0) ifb.duty_in = 13'(d);
        else          ifa.duty_in = 13'(d);
    endtask

    task automatic set_en(input logic e);
        if (sel != 0) ifb.enable = e;
        else          ifa.enable = e;
    endtask

    task automatic start();
        m_act = 0;
        set_en(1'b1);
        cyc();
        clr();
    endtask

    // Run n periods (current one included) toward target t.
    task automatic run(input int t, input int n);
        set_duty(t);
        q.push_back(m_act);
        for (int i = 1; i < n; i++) begin
            m_act = nxt(m_act, t, step);
            q.push_back(m_act);
        end
        drain();
        m_act = nxt(m_act, t, step);
    endtask

    initial begin
        ifa.enable = 1'b0; ifa.duty_in = '0;
        ifb.enable = 1'b0; ifb.duty_in = '0;
        repeat (3) cyc();
        chk("rst_pwm", int'(ifa.pwm_out), 0);
        chk("rst_duty", int'(ifa.duty_act), 0);
        chk("rst_tick", int'(ifa.period_tick), 0);
        chk("rst_duty_b", int'(ifb.duty_act), 0);
        rst = 1'b0;
        cyc();

        sel = 1; step = 0;
        start();
        run(60, 3);
        run(0, 3);
        run(8191, 2);
        set_en(1'b0);
        cyc();
        clr();
        chk("b_off_pwm", int'(ifb.pwm_out), 0);

        sel = 0; step = 5;
        start();
        run(25, 7);
        run(35, 4);
        run(20, 4);
        ifa.duty_in = 13'd0;
        repeat (10) cyc();
        run(20, 3);
        run(25, 2);

        repeat (12) cyc();
        chk("pre_dis_pwm", int'(ifa.pwm_out), 1);
        ifa.enable = 1'b0;
        cyc();
        clr();
        chk("dis_pwm", int'(ifa.pwm_out), 0);
        chk("dis_duty", int'(ifa.duty_act), 0);
        repeat (120) cyc();
        chk("idle_duty", int'(ifa.duty_act), 0);
        start();
        run(25, 3);

        repeat (3) cyc();
        chk("pre_rst_pwm", int'(ifa.pwm_out), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pwm", int'(ifa.pwm_out), 0);
        chk("arst_duty", int'(ifa.duty_act), 0);
        chk("arst_tick", int'(ifa.period_tick), 0);
        clr();
        @(posedge clk);
        cyc();
        rst = 1'b0;
        start();
        run(25, 2);

        ifa.duty_in = 13'd40;
        q.push_back(m_act);
        repeat (PER - 1) cyc();
        ifa.enable = 1'b0;
        cyc();
        clr();
        chk("wrap_dis_duty", int'(ifa.duty_act), 0);
        chk("wrap_dis_pwm", int'(ifa.pwm_out), 0);
        chk("wrap_dis_tick", int'(ifa.period_tick), 0);
        chk("wrap_dis_q", q.size(), 0);
        repeat (2 * PER) cyc();
        chk("wrap_idle_duty", int'(ifa.duty_act), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
